// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
// Build option: UART_CMD_FRAMER_CKSUM_EN adds the checksum byte and CHK state.
package uart_cmd_pkg;

    localparam logic [7:0] SOF_DEFAULT       = 8'hA5;
    localparam int         FRAME_LEN_CKSUM   = 5;
    localparam int         FRAME_LEN_NOCKSUM = 4;

`ifdef UART_CMD_FRAMER_CKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CKSUM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_DHI,
        ST_DLO,
        ST_CHK
    } state_e;
`else
    localparam int FRAME_LEN = FRAME_LEN_NOCKSUM;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPC,
        ST_DHI,
        ST_DLO
    } state_e;
`endif

    // 8-bit wraparound sum of the four checked bytes; a good frame sums to zero.
    function automatic logic [7:0] cksum8(input logic [7:0] op,
                                          input logic [7:0] hi,
                                          input logic [7:0] lo,
                                          input logic [7:0] chk);
        return op + hi + lo + chk;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter: clears on request, counts while running, and flags
// when it has sat at TIMEOUT_CYC. Saturates so it can never wrap back to zero.
module uart_byte_timer #(
    parameter int TO_W        = 20,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up to the limit while running.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Counter register with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles SOF/opcode/data-hi/data-lo[/checksum] byte frames into commands
// held on a one-entry valid/ready slot, with registered error pulses.
// Build option: UART_CMD_FRAMER_CKSUM_EN enables the checksum byte.
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SOF         = SOF_DEFAULT,
    parameter int         TO_W        = 20,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_data,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    output logic        chk_err,
    output logic        to_err,
    output logic        ovr_err
);

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  cmd_op_q, cmd_op_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic        to_err_q, to_err_d;
    logic        ovr_err_q, ovr_err_d;
    logic        frame_done, frame_good;
    logic [15:0] new_data;
    logic        expired;
`ifdef UART_CMD_FRAMER_CKSUM_EN
    logic [7:0]  lo_q, lo_d;
    logic        chk_err_q, chk_err_d;
`endif

    uart_byte_timer #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (rx_rdy || (state_q == ST_IDLE)),
        .run_i     (state_q != ST_IDLE),
        .expired_o (expired)
    );

    // Frame FSM, shadow capture, frame evaluation and output-slot control.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        cmd_op_d   = cmd_op_q;
        cmd_data_d = cmd_data_q;
        cmd_vld_d  = cmd_vld_q;
        to_err_d   = 1'b0;
        ovr_err_d  = 1'b0;
        frame_done = 1'b0;
        frame_good = 1'b0;
`ifdef UART_CMD_FRAMER_CKSUM_EN
        lo_d       = lo_q;
        chk_err_d  = 1'b0;
        new_data   = {hi_q, lo_q};
`else
        new_data   = {hi_q, rx_data};
`endif

        case (state_q)
            ST_IDLE: if (rx_rdy && (rx_data == SOF)) state_d = ST_OPC;
            ST_OPC: if (rx_rdy) begin
                op_d    = rx_data;
                state_d = ST_DHI;
            end
            ST_DHI: if (rx_rdy) begin
                hi_d    = rx_data;
                state_d = ST_DLO;
            end
`ifdef UART_CMD_FRAMER_CKSUM_EN
            ST_DLO: if (rx_rdy) begin
                lo_d    = rx_data;
                state_d = ST_CHK;
            end
            ST_CHK: if (rx_rdy) begin
                state_d    = ST_IDLE;
                frame_done = 1'b1;
                frame_good = (cksum8(op_q, hi_q, lo_q, rx_data) == 8'h00);
            end
`else
            ST_DLO: if (rx_rdy) begin
                state_d    = ST_IDLE;
                frame_done = 1'b1;
                frame_good = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A strobe in the expiry cycle wins over the timeout.
        if (expired && !rx_rdy) begin
            state_d  = ST_IDLE;
            to_err_d = 1'b1;
        end

        // Output slot: load when empty or being drained this cycle, else overrun.
        if (frame_done && frame_good) begin
            if (!cmd_vld_q || cmd_rdy) begin
                cmd_op_d   = op_q;
                cmd_data_d = new_data;
                cmd_vld_d  = 1'b1;
            end else begin
                ovr_err_d = 1'b1;
            end
        end else if (cmd_vld_q && cmd_rdy) begin
            cmd_vld_d = 1'b0;
        end

`ifdef UART_CMD_FRAMER_CKSUM_EN
        chk_err_d = frame_done && !frame_good;
`endif
    end

    // State, shadow and output registers with synchronous reset.
    // NOTE: the shadow bytes are reset too, so nothing downstream ever sees X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            hi_q       <= '0;
            cmd_op_q   <= '0;
            cmd_data_q <= '0;
            cmd_vld_q  <= 1'b0;
            to_err_q   <= 1'b0;
            ovr_err_q  <= 1'b0;
`ifdef UART_CMD_FRAMER_CKSUM_EN
            lo_q       <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            cmd_op_q   <= cmd_op_d;
            cmd_data_q <= cmd_data_d;
            cmd_vld_q  <= cmd_vld_d;
            to_err_q   <= to_err_d;
            ovr_err_q  <= ovr_err_d;
`ifdef UART_CMD_FRAMER_CKSUM_EN
            lo_q       <= lo_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    assign cmd_op   = cmd_op_q;
    assign cmd_data = cmd_data_q;
    assign cmd_vld  = cmd_vld_q;
    assign to_err   = to_err_q;
    assign ovr_err  = ovr_err_q;
`ifdef UART_CMD_FRAMER_CKSUM_EN
    assign chk_err  = chk_err_q;
`else
    assign chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: directed scenarios then random
// frames, all compared every clock against a byte-queue reference model.
// Adapts to UART_CMD_FRAMER_CKSUM_EN (5-byte vs 4-byte frames).
module tb_uart_cmd_framer;

    localparam logic [7:0] SOF = 8'hA5;
    localparam int         TO  = 16;
`ifdef UART_CMD_FRAMER_CKSUM_EN
    localparam int FLEN  = 5;
    localparam bit CKSUM = 1'b1;
`else
    localparam int FLEN  = 4;
    localparam bit CKSUM = 1'b0;
`endif

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        cmd_vld;
    logic        chk_err, to_err, ovr_err;

    always #5 clk = ~clk;

    uart_cmd_framer #(
        .SOF         (SOF),
        .TO_W        (5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .chk_err  (chk_err),
        .to_err   (to_err),
        .ovr_err  (ovr_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: bytes of the frame collected so far, idle clocks since last byte.
    bytes_t      frame;
    int          idle = 0;
    logic        exp_vld = 1'b0;
    logic [7:0]  exp_op = 8'h00;
    logic [15:0] exp_data = 16'h0000;
    logic        exp_chk = 1'b0, exp_to = 1'b0, exp_ovr = 1'b0;

    // Observed pulse counts for the directed scenarios.
    int cnt_chk = 0, cnt_to = 0, cnt_ovr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_vld"},  32'(cmd_vld),  32'(exp_vld));
        check({tag, "_op"},   32'(cmd_op),   32'(exp_op));
        check({tag, "_data"}, 32'(cmd_data), 32'(exp_data));
        check({tag, "_chk"},  32'(chk_err),  32'(exp_chk));
        check({tag, "_to"},   32'(to_err),   32'(exp_to));
        check({tag, "_ovr"},  32'(ovr_err),  32'(exp_ovr));
    endtask

    task automatic clear_counts();
        cnt_chk = 0;
        cnt_to  = 0;
        cnt_ovr = 0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_update(input logic rdy, input logic [7:0] d, input logic crdy);
        bit done, good, hs;
        int s;
        hs = exp_vld && crdy;
        exp_chk = 1'b0;
        exp_to  = 1'b0;
        exp_ovr = 1'b0;
        done = 1'b0;
        good = 1'b0;
        if (rdy) begin
            idle = 0;
            if (frame.size() != 0 || d == SOF) frame.push_back(d);
            if (frame.size() == FLEN) begin
                done = 1'b1;
                s = 0;
                for (int i = 1; i < FLEN; i++) s += int'(frame[i]);
                good = CKSUM ? ((s % 256) == 0) : 1'b1;
            end
        end else if (frame.size() != 0) begin
            idle++;
            if (idle == TO + 1) begin
                frame.delete();
                idle   = 0;
                exp_to = 1'b1;
            end
        end
        if (done && good) begin
            if (!exp_vld || crdy) begin
                exp_vld  = 1'b1;
                exp_op   = frame[1];
                exp_data = {frame[2], frame[3]};
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (hs) begin
            exp_vld = 1'b0;
        end
        if (done && !good) exp_chk = 1'b1;
        if (done) frame.delete();
    endtask

    task automatic step(input logic rdy, input logic [7:0] d, input logic crdy);
        rx_rdy  = rdy;
        rx_data = d;
        cmd_rdy = crdy;
        model_update(rdy, d, crdy);
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
        cmd_rdy = 1'b0;
        if (chk_err) cnt_chk++;
        if (to_err)  cnt_to++;
        if (ovr_err) cnt_ovr++;
        check_all("step");
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rx_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame.delete();
        idle     = 0;
        exp_vld  = 1'b0;
        exp_op   = 8'h00;
        exp_data = 16'h0000;
        exp_chk  = 1'b0;
        exp_to   = 1'b0;
        exp_ovr  = 1'b0;
        check_all("reset");
    endtask

    task automatic send_seq(input bytes_t b, input logic crdy);
        foreach (b[i]) step(1'b1, b[i], crdy);
    endtask

    // Send one frame (checksum corrupted if bad); cmd_rdy only on the final byte.
    task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                              input bit bad, input logic crdy_last);
        logic [7:0] chk;
        bytes_t     b;
        chk = 8'h00 - op - hi - lo + (bad ? 8'h01 : 8'h00);
        b = '{SOF, op, hi, lo, chk};
        for (int i = 0; i < FLEN; i++) step(1'b1, b[i], (i == FLEN - 1) ? crdy_last : 1'b0);
    endtask

    initial begin
        logic [7:0] r_op, r_hi, r_lo;
        int         kind, gap;

        // Reset state.
        do_reset();
        check("reset_vld_const", 32'(cmd_vld), 32'd0);

        // Good frame, held until cmd_rdy, then cleared next clock.
        clear_counts();
        send_seq('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h64}, 1'b0);
        check("good_vld", 32'(cmd_vld), 32'd1);
        check("good_op", 32'(cmd_op), 32'h12);
        check("good_data", 32'(cmd_data), 32'h3456);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        check("good_hold", 32'(cmd_vld), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("good_cleared", 32'(cmd_vld), 32'd0);

        // Bad checksum.
        clear_counts();
        send_seq('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h65}, 1'b0);
        check("bad_chk_pulses", 32'(cnt_chk), CKSUM ? 32'd1 : 32'd0);
        check("bad_vld", 32'(cmd_vld), CKSUM ? 32'd0 : 32'd1);
        step(1'b0, 8'h00, 1'b1);

        // Junk before SOF.
        clear_counts();
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h02, 8'hFD}, 1'b0);
        check("junk_op", 32'(cmd_op), 32'h01);
        check("junk_data", 32'(cmd_data), 32'h0002);
        check("junk_errs", 32'(cnt_chk + cnt_to + cnt_ovr), 32'd0);
        step(1'b0, 8'h00, 1'b1);

        // Inter-byte timeout, then a good frame is still accepted.
        clear_counts();
        send_seq('{8'hA5, 8'h12}, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);
        check("to_pulses", 32'(cnt_to), 32'd1);
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        check("to_after_vld", 32'(cmd_vld), 32'd1);
        check("to_after_op", 32'(cmd_op), 32'h12);
        step(1'b0, 8'h00, 1'b1);

        // Overrun while full, then load on a same-cycle handshake.
        clear_counts();
        send_frame(8'h01, 8'h00, 8'h02, 1'b0, 1'b0);
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        check("ovr_pulses", 32'(cnt_ovr), 32'd1);
        check("ovr_kept_op", 32'(cmd_op), 32'h01);
        check("ovr_kept_data", 32'(cmd_data), 32'h0002);
        clear_counts();
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, 1'b1);
        check("hs_load_ovr", 32'(cnt_ovr), 32'd0);
        check("hs_load_vld", 32'(cmd_vld), 32'd1);
        check("hs_load_op", 32'(cmd_op), 32'h12);

        // Reset mid-frame and while holding.
        send_seq('{8'hA5, 8'h12, 8'h34}, 1'b0);
        do_reset();
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        check("post_rst_data", 32'(cmd_data), 32'h3456);
        do_reset();
        check("rst_hold_vld", 32'(cmd_vld), 32'd0);

`ifndef UART_CMD_FRAMER_CKSUM_EN
        // Four-byte frame without a checksum byte.
        send_seq('{8'hA5, 8'h12, 8'h34, 8'h56}, 1'b0);
        check("nock_vld", 32'(cmd_vld), 32'd1);
        step(1'b0, 8'h00, 1'b1);
`endif

        // Random frames, junk, gaps and consumer back-pressure.
        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 9));
            r_op = 8'($urandom);
            r_hi = 8'($urandom);
            r_lo = 8'($urandom);
            if (kind == 0) begin
                for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), $urandom_range(0, 1) == 1);
            end else if (kind == 1) begin
                send_seq('{SOF, r_op}, 1'b0);
                for (int i = 0; i < 18; i++) step(1'b0, 8'($urandom), $urandom_range(0, 1) == 1);
            end else begin
                logic [7:0] chk;
                bytes_t     b;
                chk = 8'h00 - r_op - r_hi - r_lo + ((kind == 2) ? 8'h01 : 8'h00);
                b = '{SOF, r_op, r_hi, r_lo, chk};
                for (int i = 0; i < FLEN; i++) begin
                    step(1'b1, b[i], $urandom_range(0, 2) == 0);
                    gap = ($urandom_range(0, 15) == 0) ? 16 : int'($urandom_range(0, 2));
                    for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), $urandom_range(0, 2) == 0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
